// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------------------------
// fifo_uart_tx
//
// Drains an 8-bit FIFO one byte per frame and serialises it onto an asynchronous line,
// LSB first, start bit low, stop bit high, CLK_DIV clk cycles per bit.
// The FIFO is read with a single-cycle strobe only from IDLE, so it is never touched while a
// frame is on the line. Read data is expected registered, i.e. valid the cycle after the strobe.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent between the data and stop bits
//                      (11-bit frame). When undefined the frame is plain 8N1 (10 bits).
//
// Parameters:
//   CLK_DIV        clk cycles per serial bit (>= 2)
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   enable_i       allows a new byte to be fetched (only looked at in IDLE)
//   fifo_empty_i   FIFO empty flag (only looked at in IDLE)
//   fifo_re_o      FIFO read strobe, one cycle per byte
//   fifo_dout_i    FIFO registered read data
//   tx_o           serial line, idles high
//   busy_o         high whenever a byte is being fetched or sent
//   tx_done_o      one-cycle pulse in the last cycle of the stop bit
// ---------------------------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       fifo_empty_i,
    output logic       fifo_re_o,
    input  logic [7:0] fifo_dout_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       tx_done_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StLoad   = 3'd2,
        StStart  = 3'd3,
        StData   = 3'd4,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd5,
`endif
        StStop   = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    // Last clk cycle of the current serial bit.
    logic bit_end;
    assign bit_end = (baud_q == BaudLast);

    // -----------------------------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (enable_i && !fifo_empty_i) begin
                    state_d = StFetch;
                end
            end

            // Read strobe is a Moore decode of this state; the data arrives next cycle.
            StFetch: begin
                state_d = StLoad;
            end

            StLoad: begin
                shift_d  = fifo_dout_i;
                baud_d   = '0;
                bit_d    = '0;
`ifdef UART_TX_PARITY_EN
                parity_d = ^fifo_dout_i;
`endif
                state_d  = StStart;
            end

            StStart: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end

            StData: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    // 3-bit counter wraps back to 0 after bit 7.
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
`endif

            StStop: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Outputs: decoded from registers only, so enable_i / fifo_empty_i never reach fifo_re_o
    // combinationally.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        tx_o = 1'b1;
        case (state_q)
            StStart:  tx_o = 1'b0;
            StData:   tx_o = shift_q[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_o = parity_q;
`endif
            default:  tx_o = 1'b1;
        endcase
    end

    assign fifo_re_o = (state_q == StFetch);
    assign busy_o    = (state_q != StIdle);
    assign tx_done_o = (state_q == StStop) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Two transmitters (CLK_DIV = 4 and CLK_DIV = 2) fed from queue-based FIFO models. A line
// monitor slices each frame into bits and records timing; the test tasks compare those frames
// against bytes queued at stimulus time.
// ---------------------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct packed {
        logic [10:0] bits;
        logic        reg_ok;
        int          done_at;
        int          lat;
        int          gap;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] enable = 2'b00;
    logic [1:0] fifo_empty = 2'b11;
    logic [1:0] fifo_re;
    logic [1:0] tx;
    logic [1:0] busy;
    logic [1:0] tx_done;
    logic [7:0] fifo_dout [2];

    logic [7:0] fifo_q [2][$];
    logic [7:0] exp_q  [2][$];
    frame_t     got_q  [2][$];

    int         cyc = 0;
    int         pos [2] = '{0, 0};
    logic [43:0] smp [2];
    int         done_at [2] = '{-1, -1};
    int         lat [2] = '{0, 0};
    int         gap [2] = '{0, 0};
    int         last_re [2] = '{-1000, -1000};
    int         last_end [2] = '{-1000, -1000};
    int         re_cnt [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};

    int         n_tests = 0;
    int         n_fail  = 0;

    initial forever #5 clk = ~clk;

    fifo_uart_tx #(.CLK_DIV(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable[0]),
        .fifo_empty_i (fifo_empty[0]),
        .fifo_re_o    (fifo_re[0]),
        .fifo_dout_i  (fifo_dout[0]),
        .tx_o         (tx[0]),
        .busy_o       (busy[0]),
        .tx_done_o    (tx_done[0])
    );

    fifo_uart_tx #(.CLK_DIV(2)) u_dut2 (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable[1]),
        .fifo_empty_i (fifo_empty[1]),
        .fifo_re_o    (fifo_re[1]),
        .fifo_dout_i  (fifo_dout[1]),
        .tx_o         (tx[1]),
        .busy_o       (busy[1]),
        .tx_done_o    (tx_done[1])
    );

    // FIFO models: registered read data, empty flag follows the queue.
    initial forever begin
        @(posedge clk);
        if (fifo_re[0] && fifo_q[0].size() > 0) fifo_dout[0] <= fifo_q[0].pop_front();
        fifo_empty[0] <= (fifo_q[0].size() == 0);
        if (fifo_re[1] && fifo_q[1].size() > 0) fifo_dout[1] <= fifo_q[1].pop_front();
        fifo_empty[1] <= (fifo_q[1].size() == 0);
    end

    // Line monitor: samples every cycle on the falling edge.
    initial forever begin : monitor
        int     d;
        int     fl;
        frame_t f;
        @(negedge clk);
        cyc++;
        for (int g = 0; g < 2; g++) begin
            d  = (g == 0) ? 4 : 2;
            fl = NB * d;
            if (fifo_re[g]) begin
                re_cnt[g]++;
                last_re[g] = cyc;
            end
            if (tx_done[g]) done_cnt[g]++;
            if (pos[g] > 0 && !busy[g]) begin
                pos[g] = 0;
            end else if (pos[g] == 0) begin
                if (!tx[g] && busy[g]) begin
                    smp[g]     = '1;
                    smp[g][0]  = 1'b0;
                    pos[g]     = 1;
                    done_at[g] = -1;
                    lat[g]     = cyc - last_re[g];
                    gap[g]     = cyc - last_end[g] - 1;
                end
            end else begin
                smp[g][pos[g]] = tx[g];
                if (tx_done[g]) done_at[g] = pos[g] + 1;
                pos[g]++;
            end
            if (pos[g] == fl) begin
                f = '0;
                f.reg_ok = 1'b1;
                for (int b = 0; b < NB; b++) begin
                    f.bits[b] = smp[g][b*d];
                    for (int k = 1; k < d; k++) begin
                        if (smp[g][b*d+k] !== smp[g][b*d]) f.reg_ok = 1'b0;
                    end
                end
                f.done_at = done_at[g];
                f.lat     = lat[g];
                f.gap     = gap[g];
                got_q[g].push_back(f);
                last_end[g] = cyc;
                pos[g] = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input int g, input logic [7:0] b);
        fifo_q[g].push_back(b);
        exp_q[g].push_back(b);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b01, b, 1'b0};
`endif
    endfunction

    task automatic wait_frames(input int g, input int n, input int budget, output bit ok);
        int t = 0;
        while (got_q[g].size() < n && t < budget) begin
            tick();
            t++;
        end
        ok = (got_q[g].size() >= n);
    endtask

    task automatic wait_re(input int g, input int target, input int budget, output bit ok);
        int t = 0;
        while (re_cnt[g] < target && t < budget) begin
            tick();
            t++;
        end
        ok = (re_cnt[g] >= target);
    endtask

    // -----------------------------------------------------------------------------------------
    task automatic test_reset();
        logic [1:0] bad_tx = 2'b11, bad_busy = 2'b00, bad_re = 2'b00, bad_done = 2'b00;
        bit         e_tx = 0, e_busy = 0, e_re = 0, e_done = 0;
        rst    = 1'b1;
        enable = 2'b11;
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 2'b11)      begin e_tx = 1;   bad_tx = tx;        end
            if (busy !== 2'b00)    begin e_busy = 1; bad_busy = busy;    end
            if (fifo_re !== 2'b00) begin e_re = 1;   bad_re = fifo_re;   end
            if (tx_done !== 2'b00) begin e_done = 1; bad_done = tx_done; end
        end
        n_tests++;
        if (e_tx) begin n_fail++; $display("FAIL reset_tx: got %b required 11", bad_tx); end
        n_tests++;
        if (e_busy) begin n_fail++; $display("FAIL reset_busy: got %b required 00", bad_busy); end
        n_tests++;
        if (e_re) begin n_fail++; $display("FAIL reset_fifo_re: got %b required 00", bad_re); end
        n_tests++;
        if (e_done) begin n_fail++; $display("FAIL reset_tx_done: got %b required 00", bad_done); end
        n_tests++;
        if (re_cnt[0] + re_cnt[1] !== 0) begin
            n_fail++;
            $display("FAIL reset_re_count: got %0d required 0", re_cnt[0] + re_cnt[1]);
        end
    endtask

    task automatic test_single_byte();
        int         re0 = re_cnt[0];
        int         dn0 = done_cnt[0];
        bit         ok;
        frame_t     f;
        logic [7:0] e;
        push_byte(0, 8'hA5);
        wait_frames(0, 1, 400, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_timeout: got 0 frames required 1");
            return;
        end
        f = got_q[0].pop_front();
        e = exp_q[0].pop_front();
        tick(4);
        n_tests++;
        if (f.bits !== frame_bits(e)) begin
            n_fail++;
            $display("FAIL single_bits: got %b required %b", f.bits, frame_bits(e));
        end
        n_tests++;
        if (f.reg_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL single_bit_width: got irregular bit widths required %0d cycles", 4);
        end
        n_tests++;
        if (f.done_at !== NB * 4) begin
            n_fail++;
            $display("FAIL single_done_pos: got %0d required %0d", f.done_at, NB * 4);
        end
        n_tests++;
        if (f.lat !== 2) begin
            n_fail++;
            $display("FAIL single_fetch_latency: got %0d required 2", f.lat);
        end
        n_tests++;
        if (re_cnt[0] - re0 !== 1) begin
            n_fail++;
            $display("FAIL single_re_pulses: got %0d required 1", re_cnt[0] - re0);
        end
        n_tests++;
        if (done_cnt[0] - dn0 !== 1) begin
            n_fail++;
            $display("FAIL single_done_pulses: got %0d required 1", done_cnt[0] - dn0);
        end
    endtask

    task automatic test_back_to_back();
        int         re0 = re_cnt[0];
        bit         ok;
        frame_t     f;
        logic [7:0] e;
        push_byte(0, 8'h00);
        push_byte(0, 8'hFF);
        wait_frames(0, 2, 800, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d frames required 2", got_q[0].size());
            return;
        end
        for (int i = 0; i < 2; i++) begin
            f = got_q[0].pop_front();
            e = exp_q[0].pop_front();
            n_tests++;
            if (f.bits !== frame_bits(e)) begin
                n_fail++;
                $display("FAIL b2b_bits[%0d]: got %b required %b", i, f.bits, frame_bits(e));
            end
            n_tests++;
            if (f.reg_ok !== 1'b1 || f.done_at !== NB * 4) begin
                n_fail++;
                $display("FAIL b2b_timing[%0d]: got reg_ok=%b done_at=%0d required 1 and %0d",
                         i, f.reg_ok, f.done_at, NB * 4);
            end
            if (i == 1) begin
                n_tests++;
                if (f.gap !== 3) begin
                    n_fail++;
                    $display("FAIL b2b_gap: got %0d idle cycles required 3", f.gap);
                end
            end
        end
        tick(10);
        n_tests++;
        if (re_cnt[0] - re0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_re_pulses: got %0d required 2", re_cnt[0] - re0);
        end
    endtask

    task automatic test_enable_drop();
        int         re0 = re_cnt[0];
        bit         ok;
        frame_t     f;
        logic [7:0] e;
        push_byte(0, 8'h12);
        push_byte(0, 8'h34);
        wait_re(0, re0 + 1, 100, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL endrop_fetch_timeout: got no fifo_re required 1");
            return;
        end
        tick(14);
        enable[0] = 1'b0;
        wait_frames(0, 1, 400, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL endrop_frame_timeout: got 0 frames required 1");
            return;
        end
        f = got_q[0].pop_front();
        e = exp_q[0].pop_front();
        n_tests++;
        if (f.bits !== frame_bits(e)) begin
            n_fail++;
            $display("FAIL endrop_bits: got %b required %b", f.bits, frame_bits(e));
        end
        tick(60);
        n_tests++;
        if (re_cnt[0] - re0 !== 1 || busy[0] !== 1'b0 || got_q[0].size() !== 0) begin
            n_fail++;
            $display("FAIL endrop_hold: got re=%0d busy=%b frames=%0d required 1 0 0",
                     re_cnt[0] - re0, busy[0], got_q[0].size());
        end
        enable[0] = 1'b1;
        wait_frames(0, 1, 400, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL endrop_resume_timeout: got 0 frames required 1");
            return;
        end
        f = got_q[0].pop_front();
        e = exp_q[0].pop_front();
        n_tests++;
        if (f.bits !== frame_bits(e) || re_cnt[0] - re0 !== 2) begin
            n_fail++;
            $display("FAIL endrop_resume: got bits=%b re=%0d required %b 2",
                     f.bits, re_cnt[0] - re0, frame_bits(e));
        end
    endtask

    task automatic test_reset_mid_frame();
        int         re0 = re_cnt[0];
        int         dn0;
        bit         ok;
        frame_t     f;
        logic [7:0] e;
        push_byte(0, 8'h3C);
        push_byte(0, 8'h81);
        wait_re(0, re0 + 1, 100, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_fetch_timeout: got no fifo_re required 1");
            return;
        end
        // Now in LOAD; 18 more cycles lands in data bit 3.
        tick(18);
        dn0 = done_cnt[0];
        rst = 1'b1;
        tick();
        n_tests++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got tx=%b busy=%b required 1 0", tx[0], busy[0]);
        end
        rst = 1'b0;
        e = exp_q[0].pop_front();  // 0x3C is dropped by the reset
        wait_frames(0, 1, 400, ok);
        n_tests++;
        if (done_cnt[0] - dn0 !== (ok ? 1 : 0)) begin
            n_fail++;
            $display("FAIL rstmid_done_pulses: got %0d required %0d",
                     done_cnt[0] - dn0, ok ? 1 : 0);
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_frame_timeout: got 0 frames required 1");
            return;
        end
        f = got_q[0].pop_front();
        e = exp_q[0].pop_front();
        n_tests++;
        if (f.bits !== frame_bits(e) || f.reg_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_next_frame: got %b reg_ok=%b required %b 1",
                     f.bits, f.reg_ok, frame_bits(e));
        end
    endtask

    task automatic test_clkdiv2();
        bit         ok;
        frame_t     f;
        logic [7:0] e;
        push_byte(1, 8'h55);
        wait_frames(1, 1, 300, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL div2_timeout: got 0 frames required 1");
            return;
        end
        f = got_q[1].pop_front();
        e = exp_q[1].pop_front();
        n_tests++;
        if (f.bits !== frame_bits(e)) begin
            n_fail++;
            $display("FAIL div2_bits: got %b required %b", f.bits, frame_bits(e));
        end
        n_tests++;
        if (f.reg_ok !== 1'b1 || f.done_at !== NB * 2) begin
            n_fail++;
            $display("FAIL div2_timing: got reg_ok=%b done_at=%0d required 1 %0d",
                     f.reg_ok, f.done_at, NB * 2);
        end
        n_tests++;
        if (f.lat !== 2) begin
            n_fail++;
            $display("FAIL div2_fetch_latency: got %0d required 2", f.lat);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
        test_clkdiv2();
        tick(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
